// File: rtl/data_ram_arbiter.sv
// Two-master round-robin arbiter for the Ibex data bus with in-order response routing.
// Optional performance counters enabled by defining DATA_RAM_ARBITER_PERF_CNT_EN.
module data_ram_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m1_req,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              m0_err,
  output logic              m1_err,
  input  logic [AW-1:0]     m0_addr,
  input  logic [AW-1:0]     m1_addr,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [DW/8-1:0]   m0_be,
  input  logic [DW/8-1:0]   m1_be,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW-1:0]     m1_wdata,
  output logic [DW-1:0]     m0_rdata,
  output logic [DW-1:0]     m1_rdata,
  output logic              s_req,
  input  logic              s_gnt,
  input  logic              s_rvalid,
  input  logic              s_err,
  output logic [AW-1:0]     s_addr,
  output logic              s_we,
  output logic [DW/8-1:0]   s_be,
  output logic [DW-1:0]     s_wdata,
  input  logic [DW-1:0]     s_rdata
`ifdef DATA_RAM_ARBITER_PERF_CNT_EN
  ,
  output logic [31:0]       perf_m0_cnt,
  output logic [31:0]       perf_m1_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  logic                 last_grant_q, last_grant_d;
  logic [MAX_OUTST-1:0] id_mem_q, id_mem_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic sel, full, empty, push, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt_q == CW'(MAX_OUTST));
  assign empty = (cnt_q == '0);
  assign head  = id_mem_q[rd_ptr_q];

  always_comb begin
    sel = last_grant_q;
    if (m0_req && m1_req) sel = ~last_grant_q;
    else if (m0_req)      sel = 1'b0;
    else if (m1_req)      sel = 1'b1;

    // full only depends on registered count, so s_rvalid never reaches s_req
    s_req   = (sel ? m1_req : m0_req) & ~full & rst_n;
    s_addr  = sel ? m1_addr  : m0_addr;
    s_we    = sel ? m1_we    : m0_we;
    s_be    = sel ? m1_be    : m0_be;
    s_wdata = sel ? m1_wdata : m0_wdata;

    push   = s_req & s_gnt;
    m0_gnt = push & ~sel;
    m1_gnt = push & sel;

    pop       = s_rvalid & ~empty & rst_n;
    m0_rvalid = pop & ~head;
    m1_rvalid = pop & head;
    m0_err    = pop & ~head & s_err;
    m1_err    = pop & head & s_err;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    id_mem_d     = id_mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    if (push) begin
      id_mem_d[wr_ptr_q] = sel;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
      last_grant_d       = sel;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      id_mem_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      id_mem_q     <= id_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef DATA_RAM_ARBITER_PERF_CNT_EN
  logic [31:0] perf_m0_q, perf_m0_d;
  logic [31:0] perf_m1_q, perf_m1_d;
  logic [31:0] perf_cf_q, perf_cf_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    perf_m0_d = perf_m0_q;
    perf_m1_d = perf_m1_q;
    perf_cf_d = perf_cf_q;
    if (m0_gnt) perf_m0_d = sat_inc(perf_m0_q);
    if (m1_gnt) perf_m1_d = sat_inc(perf_m1_q);
    if (m0_req && m1_req && s_req) perf_cf_d = sat_inc(perf_cf_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_m0_q <= '0;
      perf_m1_q <= '0;
      perf_cf_q <= '0;
    end else begin
      perf_m0_q <= perf_m0_d;
      perf_m1_q <= perf_m1_d;
      perf_cf_q <= perf_cf_d;
    end
  end

  assign perf_m0_cnt       = perf_m0_q;
  assign perf_m1_cnt       = perf_m1_q;
  assign perf_conflict_cnt = perf_cf_q;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized bench for data_ram_arbiter against a queue-based transaction model.
module tb_data_ram_arbiter;
  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned BW        = DW / 8;
  localparam int unsigned MAX_OUTST = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_req, m1_req, m0_gnt, m1_gnt;
  logic          m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic          m0_we, m1_we, s_we;
  logic [BW-1:0] m0_be, m1_be, s_be;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
  logic          s_req, s_gnt, s_rvalid, s_err;
`ifdef DATA_RAM_ARBITER_PERF_CNT_EN
  logic [31:0]   perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt;
`endif

  data_ram_arbiter #(.AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_err(m0_err), .m1_err(m1_err),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_we(m0_we), .m1_we(m1_we),
    .m0_be(m0_be), .m1_be(m1_be), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err),
    .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata), .s_rdata(s_rdata)
`ifdef DATA_RAM_ARBITER_PERF_CNT_EN
    , .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        err;
  } rsp_t;

  // Transaction-level model: owner of each outstanding request, plus last winner.
  int    owner_q[$];
  bit    lg = 1'b1;
  rsp_t  slave_q[$];
  int    cyc = 0;
  longint unsigned pm0 = 0, pm1 = 0, pcf = 0;

  int p_req0, p_req1, p_gnt, lat_min, lat_max, p_rst, rst_cycles;
  int gnt_cnt0, gnt_cnt1, rv_cnt0, rv_cnt1, max_seen;

  function automatic longint unsigned sat(input longint unsigned v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  task automatic drive_inputs();
    if (rst_cycles > 0) begin
      rst_n = 1'b0;
      rst_cycles--;
    end else begin
      rst_n = !($urandom_range(999) < p_rst);
    end
    m0_req   = ($urandom_range(99) < p_req0);
    m1_req   = ($urandom_range(99) < p_req1);
    m0_addr  = $urandom;  m1_addr  = $urandom;
    m0_we    = $urandom_range(1); m1_we = $urandom_range(1);
    m0_be    = BW'($urandom); m1_be = BW'($urandom);
    m0_wdata = $urandom;  m1_wdata = $urandom;
    s_gnt    = ($urandom_range(99) < p_gnt);
    if (slave_q.size() > 0 && slave_q[0].due <= cyc) begin
      s_rvalid = 1'b1;
      s_rdata  = slave_q[0].data;
      s_err    = slave_q[0].err;
    end else begin
      s_rvalid = 1'b0;
      s_rdata  = $urandom;
      s_err    = $urandom_range(1);
    end
  endtask

  task automatic cycle();
    int  n;
    bit  sel, e_sreq, e_acc, e_rsp, id;
    drive_inputs();
    @(negedge clk);
    n = owner_q.size();
    if (m0_req && m1_req) sel = !lg;
    else if (m0_req)      sel = 1'b0;
    else if (m1_req)      sel = 1'b1;
    else                  sel = lg;
    e_sreq = rst_n && (sel ? m1_req : m0_req) && (n < MAX_OUTST);
    e_acc  = e_sreq && s_gnt;
    e_rsp  = rst_n && s_rvalid && (n > 0);
    id     = (n > 0) ? owner_q[0][0] : 1'b0;

    check("s_req",     s_req,     e_sreq);
    check("m0_gnt",    m0_gnt,    e_acc && !sel);
    check("m1_gnt",    m1_gnt,    e_acc && sel);
    check("m0_rvalid", m0_rvalid, e_rsp && !id);
    check("m1_rvalid", m1_rvalid, e_rsp && id);
    check("m0_err",    m0_err,    e_rsp && !id && s_err);
    check("m1_err",    m1_err,    e_rsp && id && s_err);
    check("m0_rdata",  m0_rdata,  s_rdata);
    check("m1_rdata",  m1_rdata,  s_rdata);
    if (rst_n) begin
      check("s_addr",  s_addr,  sel ? m1_addr  : m0_addr);
      check("s_we",    s_we,    sel ? m1_we    : m0_we);
      check("s_be",    s_be,    sel ? m1_be    : m0_be);
      check("s_wdata", s_wdata, sel ? m1_wdata : m0_wdata);
`ifdef DATA_RAM_ARBITER_PERF_CNT_EN
      check("perf_m0", perf_m0_cnt, pm0);
      check("perf_m1", perf_m1_cnt, pm1);
      check("perf_cf", perf_conflict_cnt, pcf);
`endif
    end

    if (e_acc && !sel) gnt_cnt0++;
    if (e_acc && sel)  gnt_cnt1++;
    if (e_rsp && !id)  rv_cnt0++;
    if (e_rsp && id)   rv_cnt1++;
    if (n > max_seen)  max_seen = n;

    if (s_rvalid) void'(slave_q.pop_front());
    if (e_acc) begin
      rsp_t r;
      r.due  = cyc + $urandom_range(lat_max, lat_min);
      r.data = $urandom;
      r.err  = ($urandom_range(3) == 0);
      slave_q.push_back(r);
    end

    if (!rst_n) begin
      owner_q.delete();
      lg = 1'b1;
      pm0 = 0; pm1 = 0; pcf = 0;
    end else begin
      if (e_rsp) void'(owner_q.pop_front());
      if (e_acc) begin
        owner_q.push_back(int'(sel));
        lg = sel;
      end
      if (e_acc && !sel) pm0 = sat(pm0);
      if (e_acc && sel)  pm1 = sat(pm1);
      if (m0_req && m1_req && e_sreq) pcf = sat(pcf);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic phase(input int r0, input int r1, input int g, input int lmin,
                       input int lmax, input int rst_pm, input int ncyc);
    p_req0 = r0; p_req1 = r1; p_gnt = g;
    lat_min = lmin; lat_max = lmax; p_rst = rst_pm;
    gnt_cnt0 = 0; gnt_cnt1 = 0; rv_cnt0 = 0; rv_cnt1 = 0; max_seen = 0;
    for (int i = 0; i < ncyc; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; rst_cycles = 2;
    m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_we = 1'b0; m1_we = 1'b0; m0_be = '0; m1_be = '0;
    m0_wdata = '0; m1_wdata = '0; s_rdata = '0;
    @(posedge clk); #1;

    phase(0, 0, 100, 1, 1, 0, 2);               // reset window
    phase(100, 0, 100, 1, 1, 0, 8);             // lone m0, single-cycle slave
    check("solo_m1_gnts", gnt_cnt1, 0);
    check("solo_m0_gnts", gnt_cnt0, 8);
    phase(100, 100, 100, 1, 1, 0, 12);          // continuous conflict alternates
    check("alt_m0_gnts", gnt_cnt0, 6);
    check("alt_m1_gnts", gnt_cnt1, 6);
    phase(100, 100, 100, 4, 4, 0, 24);          // slow slave fills the ID FIFO
    check("full_depth", max_seen, MAX_OUTST);
    phase(0, 0, 0, 1, 1, 0, 10);                // drain
    check("drained", owner_q.size(), 0);

    phase(100, 0, 100, 3, 3, 0, 1);             // one outstanding, then reset it away
    rst_cycles = 1;
    phase(0, 0, 0, 3, 3, 0, 6);
    check("stale_dropped", rv_cnt0 + rv_cnt1, 0);
    phase(100, 0, 100, 1, 1, 0, 3);
    check("post_reset_gnts", gnt_cnt0, 3);

    phase(60, 60, 70, 1, 4, 5, 3000);           // random traffic with rare resets
    phase(0, 0, 0, 1, 1, 0, 10);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-master, one-slave arbiter on the Ibex data-bus protocol (req/gnt/rvalid/err).
- Shares the single data RAM between the core data port (master 0) and a second bus master such as a DMA or debug/loader engine (master 1).
- Round-robin grant. In-order tracking of outstanding transactions, so each rvalid/rdata/err returns only to the master that issued the request.
- Placed between the masters and the data RAM slave port.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_OUTST, 2, maximum accepted-but-unanswered transactions (ID FIFO depth, ≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m0_req, m1_req  in  1  master request
- m0_gnt, m1_gnt  out  1  master grant
- m0_rvalid, m1_rvalid  out  1  response valid for that master
- m0_err, m1_err  out  1  response error for that master
- m0_addr, m1_addr  in  AW  address
- m0_we, m1_we  in  1  write enable
- m0_be, m1_be  in  DW/8  byte enables
- m0_wdata, m1_wdata  in  DW  write data
- m0_rdata, m1_rdata  out  DW  read data (both driven from s_rdata)
- s_req  out  1  slave request
- s_gnt  in  1  slave grant
- s_rvalid  in  1  slave response valid
- s_err  in  1  slave error
- s_addr  out  AW  slave address
- s_we  out  1  slave write enable
- s_be  out  DW/8  slave byte enables
- s_wdata  out  DW  slave write data
- s_rdata  in  DW  slave read data

Behaviour:
- Reset:
  - Synchronous, active-low; rst_n sampled on posedge clk.
  - Clears last_grant to 1, so master 0 wins the first conflict.
  - Clears ID FIFO (rd/wr pointers, count = 0).
  - Registered state only. All outputs are combinational from state plus inputs; while rst_n is low: s_req = 0, m*_gnt = 0, m*_rvalid = 0, m*_err = 0.
- Selection (combinational):
  - If only one master requests, select it.
  - If both request, select the master != last_grant.
  - If neither requests, sel = last_grant and s_req = 0.
- Slave request and grant:
  - s_req = selected master's req AND NOT fifo_full AND rst_n.
  - s_addr/s_we/s_be/s_wdata are muxed from the selected master.
  - m{sel}_gnt = s_gnt AND s_req; the other master's gnt = 0.
  - A request is not held off by the arbiter beyond the selection rules; zero added latency on the grant path.
- Accept (s_req AND s_gnt):
  - Push sel into the ID FIFO.
  - last_grant <= sel on the next posedge.
- Response:
  - On s_rvalid with FIFO non-empty, head = id: m{id}_rvalid = 1 and m{id}_err = s_err; the other master sees 0.
  - Pop the FIFO on the same edge.
  - Read latency is exactly the slave's latency; the arbiter adds 0 cycles.
- Simultaneous push and pop: both performed; count unchanged; pointers each advance and wrap modulo MAX_OUTST.
- Full (count == MAX_OUTST): s_req is forced 0 even if a pop occurs in the same cycle. There is no combinational path from s_rvalid to s_req.
- Empty FIFO with s_rvalid = 1 (stale response after a mid-transaction reset): response dropped, no master rvalid, no state change.
- A master dropping req before gnt is legal; the selection re-evaluates each cycle.
- Ordering: the slave answers in order, so the FIFO head always matches the response.

Optional Feature:
- Macro: DATA_RAM_ARBITER_PERF_CNT_EN.
- Defined: adds outputs perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt, each 32 bits and unsigned.
  - perf_m0_cnt / perf_m1_cnt increment on each accepted transaction of that master.
  - perf_conflict_cnt increments on each cycle where m0_req AND m1_req AND s_req.
  - All three saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Single master 0, s_gnt = 1, slave rvalid 1 cycle later: m0 reads addr 0x10 returning 0xDEADBEEF → m0_gnt same cycle; m0_rvalid with rdata 0xDEADBEEF next cycle; m1_rvalid stays 0.
- Both masters request continuously for 6 cycles after reset → grants alternate m0, m1, m0, m1, m0, m1; rvalids alternate likewise, one cycle later.
- MAX_OUTST = 2, slave grants but delays rvalid 4 cycles → two accepts, then s_req = 0 until the first rvalid pops the FIFO; third accept occurs the cycle after the pop.
- m1 write addr 0x20, be = 4'b0011, wdata 0x0000ABCD, with s_err = 1 in the response → s_we = 1, s_be = 4'b0011 on the slave; m1_err = 1 together with m1_rvalid; m0_err = 0.
- Reset asserted for 1 cycle with one transaction outstanding, then s_rvalid = 1 → no m*_rvalid; FIFO count remains 0; next m0 request granted normally.
- With DATA_RAM_ARBITER_PERF_CNT_EN, 3 m0 accepts, 2 m1 accepts and 2 conflict cycles → counters read 3, 2 and 2.
